wide_vec_stream_bridge: RTL and testbench

- Sequential bridge between a 32-bit word stream and the wide flat vectors of a DUT top.
- Slave stream side: collects N_IN words, then commits them atomically as the DUT input vector.
- Waits a fixed evaluation window, snapshots the DUT output vector, and streams it back as N_OUT words on a master stream.
- Used by the simulation/fuzzing harness when stimulus arrives serially instead of as parallel 32-bit ports.

---
 rtl/wide_vec_stream_bridge_if.sv | 26 ++
 rtl/wide_vec_stream_bridge.sv | 137 +++++++++++++
 tb/tb_wide_vec_stream_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wide_vec_stream_bridge_if.sv
// Handshake bundle between the serial stimulus harness and the wide-vector bridge.
// The s_* group carries input words toward the DUT vector, the m_* group carries
// snapshot words back out.
interface wide_vec_stream_bridge_if #(
  parameter int WORD_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;

  // Harness side: produces input words and consumes output words.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  // Bridge side.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/wide_vec_stream_bridge.sv
// Serial-to-wide bridge: gathers N_IN stream words into a staging register,
// commits them atomically onto dut_in, waits EVAL_CYCLES, snapshots dut_out and
// returns the snapshot as N_OUT stream words.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_LOAD | accepting input words into staging, dut_in held
//   ST_EVAL | dut_in committed, counting the evaluation window
//   ST_SEND | streaming snapshot words out, last word flagged
module wide_vec_stream_bridge #(
  parameter int WORD_W      = 32,
  parameter int N_IN        = 3,
  parameter int N_OUT       = 3,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  wide_vec_stream_bridge_if.slave bus,
  output logic [N_IN*WORD_W-1:0]  dut_in,
  input  logic [N_OUT*WORD_W-1:0] dut_out,
  output logic                    busy
);

  localparam int IN_W   = $clog2((N_IN > 2) ? N_IN : 2);
  localparam int OUT_W  = $clog2((N_OUT > 2) ? N_OUT : 2);
  localparam int EVAL_W = $clog2((EVAL_CYCLES > 2) ? EVAL_CYCLES : 2);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EVAL = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [IN_W-1:0]         in_idx;
  logic [OUT_W-1:0]        out_idx;
  logic [EVAL_W-1:0]       eval_cnt;
  logic [N_IN*WORD_W-1:0]  stage_q;
  logic [N_IN*WORD_W-1:0]  stage_merged;
  logic [N_OUT*WORD_W-1:0] snap_q;
  logic [WORD_W-1:0]       out_word;
  logic                    in_fire;
  logic                    out_fire;
  logic                    in_last;
  logic                    out_last;
  logic                    eval_done;

  // Handshakes are qualified by state, not by the ready outputs, so that the
  // ready/valid decode never feeds back into the next-state logic.
  assign in_fire   = (state_q == ST_LOAD) && bus.s_valid;
  assign out_fire  = (state_q == ST_SEND) && bus.m_ready;
  assign in_last   = (in_idx == IN_W'(N_IN - 1));
  assign out_last  = (out_idx == OUT_W'(N_OUT - 1));
  assign eval_done = (eval_cnt == EVAL_W'(EVAL_CYCLES - 1));

  // Staging contents with the word being accepted this cycle merged in.
  always_comb begin
    stage_merged = stage_q;
    for (int k = 0; k < N_IN; k++) begin
      if (in_idx == IN_W'(k)) stage_merged[k*WORD_W +: WORD_W] = bus.s_data;
    end
  end

  // Select the snapshot word currently being presented.
  always_comb begin
    out_word = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (out_idx == OUT_W'(j)) out_word = snap_q[j*WORD_W +: WORD_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // Next-state decode and state-only outputs, forced quiet while in reset.
  always_comb begin
    state_d     = state_q;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    bus.m_data  = '0;
    busy        = 1'b0;
    unique case (state_q)
      ST_LOAD: if (in_fire && in_last)   state_d = ST_EVAL;
      ST_EVAL: if (eval_done)            state_d = ST_SEND;
      ST_SEND: if (out_fire && out_last) state_d = ST_LOAD;
      default:                           state_d = ST_LOAD;
    endcase
    if (!rst) begin
      bus.s_ready = (state_q == ST_LOAD);
      bus.m_valid = (state_q == ST_SEND);
      bus.m_last  = (state_q == ST_SEND) && out_last;
      bus.m_data  = (state_q == ST_SEND) ? out_word : '0;
      busy        = (state_q == ST_EVAL) || (state_q == ST_SEND);
    end
  end

  // Staging, atomic commit, evaluation window and snapshot datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx   <= '0;
      out_idx  <= '0;
      eval_cnt <= '0;
      stage_q  <= '0;
      dut_in   <= '0;
      snap_q   <= '0;
    end else begin
      if (in_fire) begin
        stage_q <= stage_merged;
        if (in_last) begin
          dut_in   <= stage_merged;
          in_idx   <= '0;
          eval_cnt <= '0;
        end else begin
          in_idx <= in_idx + 1'b1;
        end
      end
      if (state_q == ST_EVAL) begin
        if (eval_done) begin
          snap_q  <= dut_out;
          out_idx <= '0;
        end else begin
          eval_cnt <= eval_cnt + 1'b1;
        end
      end
      if (out_fire) begin
        if (out_last) out_idx <= '0;
        else          out_idx <= out_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wide_vec_stream_bridge.sv
// Bench for wide_vec_stream_bridge: a table of full rounds, hand-built corner
// sequences, a second instance with a longer evaluation window driving a
// registered adder, and randomized traffic against a queue-based model.
module tb_wide_vec_stream_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cyc_cnt = 32'd0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  // Main instance: identity loopback, optionally disturbed after the snapshot.
  wide_vec_stream_bridge_if #(.WORD_W(32)) bus ();
  logic [95:0] dut_in;
  logic [95:0] dut_out;
  logic        busy;
  logic [31:0] perturb = 32'd0;
  assign dut_out = dut_in ^ {3{perturb}};

  wide_vec_stream_bridge #(.WORD_W(32), .N_IN(3), .N_OUT(3), .EVAL_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dut_in(dut_in), .dut_out(dut_out), .busy(busy)
  );

  // Second instance: 3-cycle window, registered adder in word 0, cycle stamp in word 1.
  wide_vec_stream_bridge_if #(.WORD_W(32)) bus2 ();
  logic [95:0] dut_in2;
  logic [95:0] dut_out2;
  logic        busy2;
  logic [31:0] add_q = 32'd0;
  always @(posedge clk) add_q <= dut_in2[31:0] + dut_in2[63:32];
  assign dut_out2 = {32'd0, cyc_cnt, add_q};

  wide_vec_stream_bridge #(.WORD_W(32), .N_IN(3), .N_OUT(3), .EVAL_CYCLES(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2)
  );

  typedef struct packed {
    logic [31:0] w0, w1, w2;
    logic [95:0] exp_in;
    logic [31:0] o0, o1, o2;
  } vec_t;

  vec_t        tbl [4];
  logic [95:0] model_dut_in = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_mvalid(output int n);
    n = 0;
    while (!bus.m_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic send3(input logic [31:0] w0, w1, w2, input logic [95:0] exp_in,
                       input string tag);
    logic [31:0] w [3];
    w = '{w0, w1, w2};
    chk({tag, "_s_ready_idle"}, bus.s_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = w[k];
      tick();
      if (k < 2) chk({tag, "_din_hold"}, dut_in, model_dut_in);
    end
    bus.s_valid = 1'b0;
    chk({tag, "_din_commit"}, dut_in, exp_in);
    model_dut_in = exp_in;
    chk({tag, "_busy_eval"}, busy, 1'b1);
    chk({tag, "_s_ready_eval"}, bus.s_ready, 1'b0);
  endtask

  task automatic drain(input logic [31:0] o0, o1, o2, input string tag);
    logic [31:0] o [3];
    int          n;
    o = '{o0, o1, o2};
    wait_mvalid(n);
    bus.m_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk({tag, "_m_valid"}, bus.m_valid, 1'b1);
      chk({tag, "_m_data"}, bus.m_data, o[j]);
      chk({tag, "_m_last"}, bus.m_last, (j == 2));
      chk({tag, "_s_ready_send"}, bus.s_ready, 1'b0);
      tick();
    end
    chk({tag, "_s_ready_after"}, bus.s_ready, 1'b1);
    chk({tag, "_m_valid_after"}, bus.m_valid, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic do_round(input vec_t v, input string tag);
    int n;
    bus.m_ready = 1'b1;
    send3(v.w0, v.w1, v.w2, v.exp_in, tag);
    wait_mvalid(n);
    chk({tag, "_eval_len"}, n, 1);
    drain(v.o0, v.o1, v.o2, tag);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_last", bus.m_last, 1'b0);
    chk("rst_m_data", bus.m_data, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dut_in", dut_in, 96'd0);
    rst = 1'b0;
    model_dut_in = '0;
    tick();
    chk("rst_release_s_ready", bus.s_ready, 1'b1);
  endtask

  task automatic random_rounds(input int n_rounds);
    logic [31:0] in_q [$];
    logic [31:0] out_q [$];
    int          done = 0;
    int          budget = 0;
    logic        hs_in, hs_out;
    while (done < n_rounds && budget < 5000) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data  = $urandom;
      bus.m_ready = ($urandom_range(0, 2) != 0);
      #1;
      hs_in  = bus.s_valid && bus.s_ready;
      hs_out = bus.m_valid && bus.m_ready;
      chk("rnd_no_accept_while_pending", bus.s_ready && (out_q.size() > 0), 1'b0);
      if (hs_out) begin
        if (out_q.size() == 0) begin
          chk("rnd_unexpected_output", 1'b1, 1'b0);
        end else begin
          chk("rnd_m_data", bus.m_data, out_q[0]);
          chk("rnd_m_last", bus.m_last, (out_q.size() == 1));
          void'(out_q.pop_front());
          if (out_q.size() == 0) done++;
        end
      end
      if (hs_in) in_q.push_back(bus.s_data);
      tick();
      budget++;
      if (in_q.size() == 3) begin
        model_dut_in = {in_q[2], in_q[1], in_q[0]};
        foreach (in_q[i]) out_q.push_back(in_q[i]);
        in_q.delete();
      end
      chk("rnd_dut_in", dut_in, model_dut_in);
    end
    chk("rnd_rounds_done", done, n_rounds);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] base;

    tbl[0] = '{32'h00020000, 32'h0, 32'h0, 96'h00000000_00000000_00020000,
               32'h00020000, 32'h0, 32'h0};
    tbl[1] = '{32'hDEADBEEF, 32'h1, 32'h2, 96'h00000002_00000001_DEADBEEF,
               32'hDEADBEEF, 32'h1, 32'h2};
    tbl[2] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001, 96'h00000001_80000000_FFFFFFFF,
               32'hFFFFFFFF, 32'h80000000, 32'h00000001};
    tbl[3] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 96'h0F0F0F0F_9ABCDEF0_12345678,
               32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b0;
    bus2.s_valid = 1'b0;
    bus2.s_data  = '0;
    bus2.m_ready = 1'b0;

    apply_reset();

    // Table rounds, back to back (row 1 starts right after row 0's last handshake).
    for (int i = 0; i < 4; i++) do_round(tbl[i], $sformatf("tbl%0d", i));

    // Atomic commit across an input gap.
    apply_reset();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h11111111;
    tick();
    bus.s_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("atomic_din_hold", dut_in, 96'd0);
      chk("atomic_s_ready", bus.s_ready, 1'b1);
      tick();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h22222222;
    tick();
    chk("atomic_din_hold2", dut_in, 96'd0);
    bus.s_data  = 32'h33333333;
    tick();
    bus.s_valid = 1'b0;
    chk("atomic_commit", dut_in, 96'h33333333_22222222_11111111);
    model_dut_in = 96'h33333333_22222222_11111111;
    drain(32'h11111111, 32'h22222222, 32'h33333333, "atomic");

    // Backpressure on word 1 while dut_out moves under the snapshot.
    bus.m_ready = 1'b1;
    send3(32'hA5A50001, 32'hA5A50002, 32'hA5A50003, 96'hA5A50003_A5A50002_A5A50001, "bp");
    wait_mvalid(n);
    chk("bp_m_data0", bus.m_data, 32'hA5A50001);
    tick();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      perturb = $urandom | 32'd1;
      #1;
      chk("bp_m_valid", bus.m_valid, 1'b1);
      chk("bp_m_data_hold", bus.m_data, 32'hA5A50002);
      chk("bp_m_last_hold", bus.m_last, 1'b0);
      chk("bp_s_ready", bus.s_ready, 1'b0);
      tick();
    end
    bus.m_ready = 1'b1;
    chk("bp_m_data1", bus.m_data, 32'hA5A50002);
    tick();
    chk("bp_m_data2", bus.m_data, 32'hA5A50003);
    chk("bp_m_last2", bus.m_last, 1'b1);
    tick();
    perturb = 32'd0;
    chk("bp_s_ready_after", bus.s_ready, 1'b1);

    // Reset after two input words.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hCAFE0001;
    tick();
    bus.s_data  = 32'hCAFE0002;
    tick();
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_load_s_ready_now", bus.s_ready, 1'b0);
    tick();
    chk("rst_load_s_ready", bus.s_ready, 1'b0);
    chk("rst_load_m_valid", bus.m_valid, 1'b0);
    chk("rst_load_dut_in", dut_in, 96'd0);
    rst = 1'b0;
    model_dut_in = '0;
    tick();
    chk("rst_load_release", bus.s_ready, 1'b1);
    chk("rst_load_busy", busy, 1'b0);
    do_round(tbl[3], "after_rst_load");

    // Reset while streaming out.
    bus.m_ready = 1'b0;
    send3(32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003, 96'h0BAD0003_0BAD0002_0BAD0001, "rsts");
    wait_mvalid(n);
    chk("rsts_in_send", bus.m_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rsts_m_valid_now", bus.m_valid, 1'b0);
    chk("rsts_m_data_now", bus.m_data, 32'd0);
    chk("rsts_busy_now", busy, 1'b0);
    tick();
    chk("rsts_m_valid", bus.m_valid, 1'b0);
    chk("rsts_s_ready", bus.s_ready, 1'b0);
    rst = 1'b0;
    model_dut_in = '0;
    tick();
    chk("rsts_release_s_ready", bus.s_ready, 1'b1);
    chk("rsts_release_m_valid", bus.m_valid, 1'b0);
    chk("rsts_dut_in", dut_in, 96'd0);
    do_round(tbl[1], "after_rst_send");

    // Three-cycle window with a registered adder.
    bus2.m_ready = 1'b1;
    bus2.s_valid = 1'b1;
    bus2.s_data  = 32'd5;
    tick();
    bus2.s_data  = 32'd7;
    tick();
    bus2.s_data  = 32'd0;
    tick();
    bus2.s_valid = 1'b0;
    chk("add_commit", dut_in2, 96'h00000000_00000007_00000005);
    chk("add_busy", busy2, 1'b1);
    base = cyc_cnt;
    n = 0;
    while (!bus2.m_valid && n < 50) begin
      tick();
      n++;
    end
    chk("add_eval_len", n, 3);
    chk("add_word0", bus2.m_data, 32'd12);
    chk("add_last0", bus2.m_last, 1'b0);
    tick();
    chk("add_word1_stamp", bus2.m_data, base + 32'd2);
    tick();
    chk("add_word2", bus2.m_data, 32'd0);
    chk("add_last2", bus2.m_last, 1'b1);
    tick();
    chk("add_s_ready_after", bus2.s_ready, 1'b1);

    // Randomized traffic with gaps and backpressure.
    random_rounds(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
